// File: rtl/seg_buffer.sv
// seg_buffer: four-entry segment-pattern store for a seven-segment display
// scanner. The CPU side writes raw active-low patterns or hex nibbles that
// are encoded on the way in. The scanner side reads one registered pattern
// per clock. A blank mask, a blink mask and a free-running blink counter
// combine into the registered per-digit blanking output xw.
module seg_buffer #(
  parameter int BLINK_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  // CPU write port
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic       wr_mode,
  input  logic [7:0] wr_data,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  output logic       wr_ack,
  // scanner read port
  input  logic [1:0] memaddr,
  output logic [7:0] digit,
  output logic [3:0] xw
);

  localparam logic [7:0] PAT_OFF = 8'hFF;  // every segment dark

  // Active-low seven-segment table; bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;  // F
    endcase
    return seg;
  endfunction

  logic [7:0]         entry_q [4];
  logic [7:0]         entry_d [4];
  logic [3:0]         blank_q, blank_d;
  logic [3:0]         blink_q, blink_d;
  logic [BLINK_W-1:0] bcnt_q,  bcnt_d;
  logic [7:0]         digit_q, digit_d;
  logic [3:0]         xw_q,    xw_d;
  logic               ack_q,   ack_d;
  logic [7:0]         wr_pat;
  logic               phase;

  // Pattern to store: raw byte, or {dp off flag, encoded nibble}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    wr_pat = wr_data;
    if (wr_mode) begin
      wr_pat = {~wr_data[4], seg7(wr_data[3:0])};
    end
  end

  assign phase = bcnt_q[BLINK_W-1];

  // Next-state for entries, masks, counter and the registered outputs.
  always_comb begin
    entry_d = entry_q;
    blank_d = blank_q;
    blink_d = blink_q;
    bcnt_d  = bcnt_q + BLINK_W'(1);  // wraps naturally from all-ones
    if (wr_en) begin
      entry_d[wr_addr] = wr_pat;
    end
    if (cfg_we) begin
      blank_d = cfg_data[3:0];
      blink_d = cfg_data[7:4];
    end
    // Reads see the pre-edge entry, so a same-cycle write to the slot being
    // scanned shows up one clock later.
    digit_d = entry_q[memaddr];
    xw_d    = blank_q | (blink_q & {4{phase}});
    ack_d   = wr_en | cfg_we;
  end

  // State registers; reset blanks every digit and discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the store is only four bytes of flops, so it is reset like any other register to guarantee a dark display after reset.
      for (int i = 0; i < 4; i++) begin
        entry_q[i] <= PAT_OFF;
      end
      blank_q <= '0;
      blink_q <= '0;
      bcnt_q  <= '0;
      digit_q <= PAT_OFF;
      xw_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      entry_q <= entry_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      digit_q <= digit_d;
      xw_q    <= xw_d;
      ack_q   <= ack_d;
    end
  end

  assign digit  = digit_q;
  assign xw     = xw_q;
  assign wr_ack = ack_q;

endmodule

// File: tb/tb_seg_buffer.sv
// Directed testbench for seg_buffer with a 4-bit blink counter.
module tb_seg_buffer;

  localparam int BW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_mode, cfg_we;
  logic [1:0] wr_addr, memaddr;
  logic [7:0] wr_data, cfg_data;
  logic       wr_ack;
  logic [7:0] digit;
  logic [3:0] xw;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference blink counter: counts edges since reset release.
  logic [BW-1:0] mcnt;

  seg_buffer #(.BLINK_W(BW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mode  (wr_mode),
    .wr_data  (wr_data),
    .cfg_we   (cfg_we),
    .cfg_data (cfg_data),
    .wr_ack   (wr_ack),
    .memaddr  (memaddr),
    .digit    (digit),
    .xw       (xw)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= '0;
    else        mcnt <= mcnt + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] hex_in  [4] = '{8'h00, 8'h01, 8'h18, 8'h0F};
  logic [7:0] hex_exp [4] = '{8'hC0, 8'hF9, 8'h00, 8'h8E};

  initial begin
    logic       ph;
    logic [3:0] prev_xw;
    int         run, toggles;

    rst_n = 1'b0; wr_en = 1'b0; wr_mode = 1'b0; cfg_we = 1'b0;
    wr_addr = '0; wr_data = '0; cfg_data = '0; memaddr = '0;
    tick(); tick();
    check("rst_digit", digit, 8'hFF);
    check("rst_xw", xw, 4'h0);
    check("rst_ack", wr_ack, 1'b0);
    rst_n = 1'b1;

    // Empty store reads all dark.
    for (int i = 0; i < 4; i++) begin
      memaddr = 2'(i);
      tick();
      check($sformatf("init_rd%0d", i), digit, 8'hFF);
    end

    // Hex-encoded writes; ack one cycle after each accepted strobe.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_mode = 1'b1; wr_addr = 2'(i); wr_data = hex_in[i];
      tick();
      wr_en = 1'b0;
      check($sformatf("hex_ack%0d", i), wr_ack, 1'b1);
      tick();
      check($sformatf("hex_ack_clr%0d", i), wr_ack, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      memaddr = 2'(i);
      tick();
      check($sformatf("hex_rd%0d", i), digit, hex_exp[i]);
    end

    // Raw write to the slot being scanned: old value first, new one next.
    memaddr = 2'd2;
    tick();
    check("rbw_before", digit, 8'h00);
    wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 2'd2; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    check("rbw_old", digit, 8'h00);
    tick();
    check("rbw_new", digit, 8'h5A);

    // Back-to-back writes hold ack high continuously.
    wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 2'd1; wr_data = 8'hA5;
    tick();
    check("b2b_ack0", wr_ack, 1'b1);
    wr_addr = 2'd1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    check("b2b_ack1", wr_ack, 1'b1);
    memaddr = 2'd1;
    tick();
    check("b2b_ack_clr", wr_ack, 1'b0);
    tick();
    check("b2b_last_wins", digit, 8'h3C);

    // Both strobes in one cycle: entry and masks both land, single ack.
    wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 2'd3; wr_data = 8'h77;
    cfg_we = 1'b1; cfg_data = 8'h0F;
    memaddr = 2'd3;
    tick();
    wr_en = 1'b0; cfg_we = 1'b0;
    check("sim_ack", wr_ack, 1'b1);
    tick();
    check("sim_ack_clr", wr_ack, 1'b0);
    check("sim_digit", digit, 8'h77);
    check("sim_xw", xw, 4'hF);

    // Blink: blank digit 0, blink digit 1; run across two counter wraps.
    cfg_we = 1'b1; cfg_data = 8'h21;
    tick();
    cfg_we = 1'b0;
    run = 0; toggles = 0;
    prev_xw = 4'hx;
    for (int c = 0; c < 2 * (1 << BW) + 3; c++) begin
      ph = mcnt[BW-1];
      tick();
      check($sformatf("blink_c%0d", c), xw, ph ? 4'b0011 : 4'b0001);
      if (c > 0 && xw !== prev_xw) begin
        if (toggles > 0) check($sformatf("blink_run_c%0d", c), run, 8);
        toggles++;
        run = 0;
      end
      run++;
      prev_xw = xw;
    end
    check("blink_toggled", (toggles >= 3), 1'b1);

    // Asynchronous reset during a write: outputs clear before any edge.
    memaddr = 2'd0;
    tick();
    check("pre_rst_digit", digit, 8'hC0);
    check("pre_rst_xw_b0", xw[0], 1'b1);
    wr_en = 1'b1; wr_mode = 1'b0; wr_addr = 2'd0; wr_data = 8'h11;
    cfg_we = 1'b1; cfg_data = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    check("arst_digit", digit, 8'hFF);
    check("arst_xw", xw, 4'h0);
    check("arst_ack", wr_ack, 1'b0);
    tick();
    wr_en = 1'b0; cfg_we = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memaddr = 2'(i);
      tick();
      check($sformatf("post_rst_rd%0d", i), digit, 8'hFF);
      check($sformatf("post_rst_xw%0d", i), xw, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_buffer.md
# seg_buffer

Four-entry segment-pattern buffer that answers the seven-segment display scanner's digit fetches. The scanner presents a 2-bit `memaddr`; this block returns the stored 8-bit active-low segment pattern on `digit` and drives the per-digit blanking mask `xw`. The CPU-side write port loads entries either as raw segment patterns or as hex nibbles encoded on the way in. A programmable blink mask and a blanking mask combine into `xw`.

## Interface

Parameters:
- `BLINK_W`, default 24: width of the free-running blink counter. Blink half-period is 2^(BLINK_W-1) clocks.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write strobe for a digit entry; sampled each rising edge.
- `wr_addr`  in  2  entry index 0..3; entry 0 is scanner slot 2'b00 (rightmost digit).
- `wr_mode`  in  1  0 = raw pattern write; 1 = hex-encode write.
- `wr_data`  in  8  raw mode: pattern as stored. Hex mode: [3:0] = nibble, [4] = decimal point on, [7:5] ignored.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_data`  in  8  [3:0] = blank mask; [7:4] = blink mask. Bit i controls digit i.
- `wr_ack`  out  1  one-cycle pulse, one cycle after an accepted `wr_en` or `cfg_we`.
- `memaddr`  in  2  digit index from the scanner.
- `digit`  out  8  registered segment pattern for `memaddr`.
- `xw`  out  4  registered blanking mask; 1 = digit forced off.

## Operation

Pattern format:
- Active-low: a 0 bit lights its segment.
- bit0 = a, bit1 = b, ..., bit6 = g, bit7 = dp.

Hex encoding (`wr_mode` = 1):
- Stored value is {~wr_data[4], seg7(wr_data[3:0])}.
- seg7 is the standard active-low table: 0 → 7'h40, 1 → 7'h79, 2 → 7'h24, 3 → 7'h30, 4 → 7'h19, 5 → 7'h12, 6 → 7'h02, 7 → 7'h78, 8 → 7'h00, 9 → 7'h10, A → 7'h08, b → 7'h03, C → 7'h46, d → 7'h21, E → 7'h06, F → 7'h0E.
- Example: nibble 0 with dp off stores 8'hC0.

Writes:
- `wr_en` high: the entry at `wr_addr` is updated at that edge.
- `cfg_we` high: the blank and blink mask registers are updated at that edge.
- Both strobes in the same cycle: both updates take effect, and `wr_ack` pulses once.
- Writes are always accepted. There is no backpressure and no busy state.

Read path:
- `digit` <= entry[`memaddr`] every clock.
- Write to entry k while `memaddr` = k in the same cycle: `digit` shows the old value that cycle and the new value the following cycle (read-before-write).

Blink:
- Counter `bcnt` (`BLINK_W` bits) increments every clock and wraps from all-ones to 0.
- phase = bcnt[BLINK_W-1].
- `xw`[i] <= blank[i] | (blink[i] & phase).
- Mask changes take effect on `xw` one clock after the `cfg_we` edge. Phase is not reset by configuration writes.

Reset (`rst_n` low, asynchronous, any time including mid-write):
- All entries = 8'hFF (all segments off).
- `digit` = 8'hFF, `xw` = 4'h0, `wr_ack` = 0.
- blank = 0, blink = 0, `bcnt` = 0.
- A write coincident with reset assertion is discarded.
- First write is accepted on the first rising edge after `rst_n` goes high.

## Timing

- Read latency: 1 clock from `memaddr` to `digit`. The scanner holds `memaddr` for 2^14 clocks per slot, so the stale first cycle is invisible.
- Write-to-visible latency: entry updates at edge N. `digit` reflects it at edge N+1 if `memaddr` matches.
- `wr_ack`: high for exactly the cycle after edge N. Back-to-back writes give `wr_ack` high continuously.
- `xw` latency: 1 clock from mask or phase change.
- Blink period: 2^BLINK_W clocks, 50% duty.

## Test plan

- Reset: assert `rst_n` = 0 mid-simulation with `wr_en` = 1 → `digit` = 8'hFF and `xw` = 0 immediately, without waiting for a clock edge. After release, reading all four `memaddr` values → 8'hFF each.
- Hex writes:
  - `wr_mode` = 1, `wr_addr` = 0..3, `wr_data` = 8'h00, 8'h01, 8'h18, 8'h0F → entries read back C0, F9, 00, 8E.
  - `wr_ack` pulses once per write, one cycle late.
- Raw write and read-before-write: `wr_mode` = 0, `wr_addr` = 2, `wr_data` = 8'h5A while `memaddr` = 2 and the entry holds 8'h00 → `digit` = 8'h00 for one cycle, then 8'h5A.
- Blank and blink with `BLINK_W` = 4:
  - `cfg_data` = 8'h21 → `xw` = 4'b0001 when bcnt[3] = 0 and 4'b0011 when bcnt[3] = 1.
  - `xw` toggles every 8 clocks.
- Simultaneous strobes: `wr_en` and `cfg_we` in the same cycle → both the entry and the masks are updated, and `wr_ack` is high for a single cycle.
- Counter wrap: run 2^BLINK_W + 3 clocks → phase sequence continues without glitch across the wrap.
